// File: rtl/ascon_job_arbiter.sv
// Round-robin arbiter that shares one Ascon AEAD core between NREQ requesters.
// It latches the operands of the granted job, sequences the core, and returns the result with a watchdog abort.
//
// state | meaning
// IDLE  | no job; arbitrate among pending requests and latch the winner's operands
// LOAD  | grant pulse to the winner, advance round-robin pointer
// START | single-cycle start pulse to the core, clear watchdog
// WAIT  | wait for a fresh core_ready (low seen, then high) or watchdog expiry
// DONE  | hold result valid to the owner until it accepts
module ascon_job_arbiter #(
  parameter int NREQ   = 2,
  parameter int K      = 128,
  parameter int L      = 32,
  parameter int Y      = 32,
  parameter int TO_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_dec,
  input  logic [NREQ*K-1:0]   req_key,
  input  logic [NREQ*128-1:0] req_nonce,
  input  logic [NREQ*L-1:0]   req_ad,
  input  logic [NREQ*Y-1:0]   req_din,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     resp_valid,
  input  logic [NREQ-1:0]     resp_ready,
  output logic [Y-1:0]        resp_data,
  output logic [127:0]        resp_tag,
  output logic                resp_err,
  output logic                busy,
  output logic                core_start,
  output logic                core_dec,
  output logic [K-1:0]        core_key,
  output logic [127:0]        core_nonce,
  output logic [L-1:0]        core_ad,
  output logic [Y-1:0]        core_din,
  input  logic [Y-1:0]        core_dout,
  input  logic [127:0]        core_tag,
  input  logic                core_ready
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TO_CYC);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   g_q;
  logic [GW-1:0]   rr_q;
  logic            armed_q;
  logic [WW-1:0]   wdog_q;
  logic            dec_q;
  logic [K-1:0]    key_q;
  logic [127:0]    nonce_q;
  logic [L-1:0]    ad_q;
  logic [Y-1:0]    din_q;
  logic [Y-1:0]    data_q;
  logic [127:0]    tag_q;
  logic            err_q;

  logic            pick_valid;
  logic [GW-1:0]   pick_idx;
  logic            job_done;
  logic            job_abort;
  logic [NREQ-1:0] owner_vec;

  // First pending request at or after the pointer, wrapping modulo NREQ.
  always_comb begin : arbitrate
    int            idx;
    logic [GW-1:0] cand;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    cand       = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = GW'(idx);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Completion wins over the watchdog when both happen in the same cycle.
  assign job_done  = armed_q && core_ready;
  assign job_abort = !job_done && (wdog_q == WDOG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (job_done || job_abort) state_d = S_DONE;
      S_DONE:  if (resp_ready[g_q]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      rr_q    <= '0;
      armed_q <= 1'b0;
      wdog_q  <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      nonce_q <= '0;
      ad_q    <= '0;
      din_q   <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_valid) begin
            g_q     <= pick_idx;
            dec_q   <= req_dec[pick_idx];
            key_q   <= req_key[pick_idx*K +: K];
            nonce_q <= req_nonce[pick_idx*128 +: 128];
            ad_q    <= req_ad[pick_idx*L +: L];
            din_q   <= req_din[pick_idx*Y +: Y];
          end
        end
        S_LOAD: begin
          if (int'(g_q) == NREQ - 1) rr_q <= '0;
          else                       rr_q <= g_q + GW'(1);
        end
        S_START: begin
          armed_q <= 1'b0;
          wdog_q  <= '0;
          err_q   <= 1'b0;
        end
        S_WAIT: begin
          // A ready left high by the previous job is ignored until it has dropped once.
          if (!core_ready) armed_q <= 1'b1;
          if (job_done) begin
            data_q <= core_dout;
            tag_q  <= core_tag;
            err_q  <= 1'b0;
          end else if (job_abort) begin
            data_q <= '0;
            tag_q  <= '0;
            err_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign owner_vec  = {{(NREQ-1){1'b0}}, 1'b1} << g_q;
  assign gnt        = (state_q == S_LOAD) ? owner_vec : '0;
  assign resp_valid = (state_q == S_DONE) ? owner_vec : '0;
  assign resp_data  = data_q;
  assign resp_tag   = tag_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != S_IDLE);
  assign core_start = (state_q == S_START);
  assign core_dec   = dec_q;
  assign core_key   = key_q;
  assign core_nonce = nonce_q;
  assign core_ad    = ad_q;
  assign core_din   = din_q;

endmodule

// File: tb/tb_ascon_job_arbiter.sv
// Bench for ascon_job_arbiter: behavioural Ascon-core stand-in plus a scoreboard of expected responses.
// Each scenario task drives requests, pushes expectations, and compares when a response appears.
module tb_ascon_job_arbiter;

  localparam int NREQ = 2;
  localparam int K    = 128;
  localparam int L    = 32;
  localparam int Y    = 32;
  localparam int TO   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_dec = '0;
  logic [NREQ*K-1:0]   req_key = '0;
  logic [NREQ*128-1:0] req_nonce = '0;
  logic [NREQ*L-1:0]   req_ad = '0;
  logic [NREQ*Y-1:0]   req_din = '0;
  logic [NREQ-1:0]     gnt, resp_valid;
  logic [NREQ-1:0]     resp_ready = '0;
  logic [Y-1:0]        resp_data;
  logic [127:0]        resp_tag;
  logic                resp_err, busy, core_start, core_dec;
  logic [K-1:0]        core_key;
  logic [127:0]        core_nonce;
  logic [L-1:0]        core_ad;
  logic [Y-1:0]        core_din;
  logic [Y-1:0]        core_dout;
  logic [127:0]        core_tag;
  logic                core_ready;

  always #5 clk = ~clk;

  ascon_job_arbiter #(.NREQ(NREQ), .K(K), .L(L), .Y(Y), .TO_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dec(req_dec), .req_key(req_key),
    .req_nonce(req_nonce), .req_ad(req_ad), .req_din(req_din), .gnt(gnt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .resp_err(resp_err), .busy(busy), .core_start(core_start),
    .core_dec(core_dec), .core_key(core_key), .core_nonce(core_nonce), .core_ad(core_ad),
    .core_din(core_din), .core_dout(core_dout), .core_tag(core_tag), .core_ready(core_ready)
  );

  typedef struct {
    logic [NREQ-1:0] who;
    logic            err;
    logic [Y-1:0]    data;
    logic [127:0]    tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   k = 0;

  logic [K-1:0]   op_key[NREQ];
  logic [127:0]   op_nonce[NREQ];
  logic [L-1:0]   op_ad[NREQ];
  logic [Y-1:0]   op_din[NREQ];
  logic           op_dec[NREQ];

  int core_lat   = 6;
  bit keep_stale = 1'b0;
  int stale_cyc  = 0;
  bit never      = 1'b0;

  // Stand-in cipher: any fixed mixing of all operands exposes wrong operand latching.
  function automatic logic [Y-1:0] f_data(input logic [Y-1:0] din, input logic [K-1:0] key,
                                          input logic dec);
    return din ^ key[31:0] ^ (dec ? 32'hFFFF_FFFF : 32'h0000_0000);
  endfunction

  function automatic logic [127:0] f_tag(input logic [K-1:0] key, input logic [127:0] nonce,
                                         input logic [L-1:0] ad, input logic dec);
    return key ^ nonce ^ {96'd0, ad} ^ {127'd0, dec};
  endfunction

  initial begin : core_model
    int cnt;
    bit active;
    cnt = 0;
    active = 1'b0;
    core_ready = 1'b0;
    core_dout = '0;
    core_tag = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
        core_ready = 1'b0;
      end else if (core_start) begin
        active = 1'b1;
        cnt = 0;
        if (!keep_stale) core_ready = 1'b0;
      end else if (active) begin
        cnt++;
        if (keep_stale && cnt == stale_cyc) core_ready = 1'b0;
        if (!never && cnt == core_lat) begin
          core_ready = 1'b1;
          core_dout = f_data(core_din, core_key, core_dec);
          core_tag = f_tag(core_key, core_nonce, core_ad, core_dec);
          active = 1'b0;
        end
      end
    end
  end

  task automatic apply_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_key[i*K +: K]       = op_key[i];
      req_nonce[i*128 +: 128] = op_nonce[i];
      req_ad[i*L +: L]        = op_ad[i];
      req_din[i*Y +: Y]       = op_din[i];
      req_dec[i]              = op_dec[i];
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] s, input logic d);
    op_key[i]   = {s, ~s, s + 32'd7, s ^ 32'hA5A5_5A5A};
    op_nonce[i] = {s ^ 32'h0F0F_0F0F, s, ~s, s + 32'd99};
    op_ad[i]    = s * 32'd3;
    op_din[i]   = s + 32'h1234;
    op_dec[i]   = d;
    apply_ops();
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.who  = (i == 0) ? 2'b01 : 2'b10;
    e.err  = 1'b0;
    e.data = f_data(op_din[i], op_key[i], op_dec[i]);
    e.tag  = f_tag(op_key[i], op_nonce[i], op_ad[i], op_dec[i]);
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  task automatic wait_gnt(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i <= maxc; i++) begin
      if (|gnt) begin
        to = 1'b0;
        return;
      end
      step();
    end
  endtask

  task automatic wait_valid(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i <= maxc; i++) begin
      if (|resp_valid) begin
        to = 1'b0;
        return;
      end
      step();
    end
  endtask

  task automatic accept();
    resp_ready = resp_valid;
    step();
    resp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, resp_valid, core_start, busy, resp_err} !== 7'd0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {gnt, resp_valid, core_start, busy, resp_err});
    end
    checks++;
    if ({resp_data, resp_tag, core_key, core_din, core_dec} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {resp_data, resp_tag, core_key, core_din, core_dec});
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({busy, gnt} !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=0", {busy, gnt});
    end
  endtask

  task automatic test_round_robin();
    bit to;
    exp_t e;
    logic [NREQ-1:0] exp_g;
    set_ops(0, 32'h1000_0001, 1'b0);
    set_ops(1, 32'h2000_0002, 1'b1);
    core_lat = 3;
    k = 0;
    req = 2'b11;
    for (int j = 0; j < 4; j++) push_exp(j % 2);
    for (int j = 0; j < 4; j++) begin
      exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(20, to);
      checks++;
      if (to || gnt !== exp_g) begin
        failures++;
        $display("FAIL rr_order job=%0d got=%b exp=%b timeout=%0d", j, gnt, exp_g, to);
      end
      if (j == 3) req = '0;
      wait_valid(30, to);
      checks++;
      if (to || sb.size() == 0) begin
        failures++;
        $display("FAIL rr_resp_missing job=%0d got=%b", j, resp_valid);
      end else begin
        e = sb.pop_front();
        if ({resp_valid, resp_err, resp_data, resp_tag} !== {e.who, e.err, e.data, e.tag}) begin
          failures++;
          $display("FAIL rr_resp job=%0d got=%h exp=%h", j, {resp_valid, resp_err, resp_data, resp_tag},
                   {e.who, e.err, e.data, e.tag});
        end
      end
      accept();
    end
  endtask

  task automatic test_single();
    bit to;
    exp_t e;
    set_ops(0, 32'h3333_0001, 1'b0);
    core_lat = 6;
    k = 0;
    req = 2'b01;
    push_exp(0);
    step();
    checks++;
    if ({gnt, core_start, busy} !== 4'b0101) begin
      failures++;
      $display("FAIL single_gnt_c1 got=%b exp=0101", {gnt, core_start, busy});
    end
    req = '0;
    step();
    checks++;
    if ({gnt, core_start} !== 3'b001) begin
      failures++;
      $display("FAIL single_start_c2 got=%b exp=001", {gnt, core_start});
    end
    checks++;
    if ({core_dec, core_key, core_din} !== {op_dec[0], op_key[0], op_din[0]}) begin
      failures++;
      $display("FAIL single_operands got=%h exp=%h", {core_dec, core_key, core_din},
               {op_dec[0], op_key[0], op_din[0]});
    end
    set_ops(0, 32'hDEAD_BEEF, 1'b1);
    wait_valid(30, to);
    checks++;
    if (to || k != 9) begin
      failures++;
      $display("FAIL single_latency got=%0d exp=9 timeout=%0d", k, to);
    end
    checks++;
    if (to || sb.size() == 0) begin
      failures++;
      $display("FAIL single_resp_missing got=%b", resp_valid);
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_err, resp_data, resp_tag} !== {e.who, e.err, e.data, e.tag}) begin
        failures++;
        $display("FAIL single_resp got=%h exp=%h", {resp_valid, resp_err, resp_data, resp_tag},
                 {e.who, e.err, e.data, e.tag});
      end
    end
    accept();
    checks++;
    if ({resp_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL single_release got=%b exp=000", {resp_valid, busy});
    end
  endtask

  task automatic test_stale();
    bit to;
    exp_t e;
    set_ops(1, 32'h4444_0004, 1'b1);
    keep_stale = 1'b1;
    stale_cyc = 3;
    core_lat = 6;
    k = 0;
    req = 2'b10;
    push_exp(1);
    step();
    req = '0;
    wait_valid(30, to);
    checks++;
    if (to || k != 9) begin
      failures++;
      $display("FAIL stale_latency got=%0d exp=9 timeout=%0d", k, to);
    end
    checks++;
    if (to || sb.size() == 0) begin
      failures++;
      $display("FAIL stale_resp_missing got=%b", resp_valid);
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_err, resp_data, resp_tag} !== {e.who, e.err, e.data, e.tag}) begin
        failures++;
        $display("FAIL stale_resp got=%h exp=%h", {resp_valid, resp_err, resp_data, resp_tag},
                 {e.who, e.err, e.data, e.tag});
      end
    end
    accept();
    keep_stale = 1'b0;
  endtask

  task automatic test_watchdog();
    bit to;
    exp_t e;
    set_ops(0, 32'h5555_0005, 1'b0);
    never = 1'b1;
    k = 0;
    req = 2'b01;
    e.who = 2'b01;
    e.err = 1'b1;
    e.data = '0;
    e.tag = '0;
    sb.push_back(e);
    step();
    req = '0;
    wait_valid(40, to);
    checks++;
    if (to || k != 19) begin
      failures++;
      $display("FAIL wdog_latency got=%0d exp=19 timeout=%0d", k, to);
    end
    checks++;
    if (to || sb.size() == 0) begin
      failures++;
      $display("FAIL wdog_resp_missing got=%b", resp_valid);
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_err, resp_data, resp_tag} !== {e.who, e.err, e.data, e.tag}) begin
        failures++;
        $display("FAIL wdog_resp got=%h exp=%h", {resp_valid, resp_err, resp_data, resp_tag},
                 {e.who, e.err, e.data, e.tag});
      end
    end
    accept();
    never = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to;
    exp_t e;
    set_ops(0, 32'h6666_0006, 1'b0);
    set_ops(1, 32'h7777_0007, 1'b0);
    core_lat = 2;
    k = 0;
    req = 2'b01;
    push_exp(0);
    push_exp(1);
    step();
    req = 2'b10;
    resp_ready = 2'b10;
    wait_valid(20, to);
    checks++;
    if (to || k != 5) begin
      failures++;
      $display("FAIL bp_best_latency got=%0d exp=5 timeout=%0d", k, to);
    end
    if (sb.size() != 0) e = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({gnt, resp_valid, resp_err, resp_data, resp_tag} !== {2'b00, e.who, e.err, e.data, e.tag}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i, {gnt, resp_valid, resp_err, resp_data, resp_tag},
                 {2'b00, e.who, e.err, e.data, e.tag});
      end
      step();
    end
    resp_ready = 2'b01;
    step();
    resp_ready = '0;
    checks++;
    if ({resp_valid, gnt} !== 4'b0000) begin
      failures++;
      $display("FAIL bp_accept got=%b exp=0000", {resp_valid, gnt});
    end
    step();
    checks++;
    if (gnt !== 2'b10) begin
      failures++;
      $display("FAIL bp_next_gnt got=%b exp=10", gnt);
    end
    req = '0;
    wait_valid(20, to);
    checks++;
    if (to || sb.size() == 0) begin
      failures++;
      $display("FAIL bp_resp1_missing got=%b", resp_valid);
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_err, resp_data, resp_tag} !== {e.who, e.err, e.data, e.tag}) begin
        failures++;
        $display("FAIL bp_resp1 got=%h exp=%h", {resp_valid, resp_err, resp_data, resp_tag},
                 {e.who, e.err, e.data, e.tag});
      end
    end
    accept();
  endtask

  task automatic test_reset_mid_job();
    bit to;
    exp_t e;
    set_ops(0, 32'h8888_0008, 1'b0);
    set_ops(1, 32'h9999_0009, 1'b1);
    never = 1'b1;
    k = 0;
    req = 2'b01;
    step();
    req = '0;
    while (k < 6) step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_busy got=%b exp=1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, resp_valid, core_start, busy, resp_err, core_key, core_din, resp_data} !== '0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=0", {gnt, resp_valid, core_start, busy, resp_err, core_key, core_din, resp_data});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    never = 1'b0;
    core_lat = 3;
    k = 0;
    req = 2'b11;
    push_exp(0);
    push_exp(1);
    for (int j = 0; j < 2; j++) begin
      wait_gnt(10, to);
      checks++;
      if (to || gnt !== ((j == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rst_rr_gnt job=%0d got=%b exp=%b timeout=%0d", j, gnt, (j == 0) ? 2'b01 : 2'b10, to);
      end
      req = (j == 0) ? 2'b10 : 2'b00;
      wait_valid(20, to);
      checks++;
      if (to || sb.size() == 0) begin
        failures++;
        $display("FAIL rst_resp_missing job=%0d got=%b", j, resp_valid);
      end else begin
        e = sb.pop_front();
        if ({resp_valid, resp_err, resp_data, resp_tag} !== {e.who, e.err, e.data, e.tag}) begin
          failures++;
          $display("FAIL rst_resp job=%0d got=%h exp=%h", j, {resp_valid, resp_err, resp_data, resp_tag},
                   {e.who, e.err, e.data, e.tag});
        end
      end
      accept();
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'd0, 1'b0);
    test_reset();
    test_round_robin();
    test_single();
    test_stale();
    test_watchdog();
    test_backpressure();
    test_reset_mid_job();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
